// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared prescaled counter, edge- or center-aligned,
// with duty and enable double-buffered so changes only land on period boundaries.
module pwm_multi_channel #(
  parameter int CHANNELS   = 8,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8,
  parameter int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  duty_we,
  input  logic [SEL_W-1:0]      duty_sel,
  input  logic [WIDTH-1:0]      duty_data,
  input  logic [CHANNELS-1:0]   ch_en,
  input  logic                  center_mode,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_start
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [WIDTH-1:0]      cnt;
  dir_t                  dir;
  logic                  mode_act;
  logic [WIDTH-1:0]      duty_sh  [CHANNELS];
  logic [WIDTH-1:0]      duty_act [CHANNELS];
  logic [CHANNELS-1:0]   en_sh;
  logic [CHANNELS-1:0]   en_act;
  logic                  tick;
  logic                  boundary;

  // The >= compare keeps the prescaler from stalling when prescale is lowered mid-count.
  assign tick     = (pre_cnt >= prescale);
  assign boundary = tick && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      dir      <= UP;
      mode_act <= 1'b0;
      en_act   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_act[i] <= '0;
      end
    end else if (tick) begin
      if (cnt == '0) begin
        cnt      <= WIDTH'(1);
        dir      <= UP;
        mode_act <= center_mode;
        en_act   <= en_sh;
        for (int i = 0; i < CHANNELS; i++) begin
          duty_act[i] <= duty_sh[i];
        end
      end else if (!mode_act) begin
        cnt <= cnt + WIDTH'(1);
      end else if (dir == UP) begin
        if (cnt == MAX) begin
          dir <= DOWN;
          cnt <= MAX - WIDTH'(1);
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end else begin
        cnt <= cnt - WIDTH'(1);
      end
    end
  end

  // Out-of-range selects match no channel and are silently dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_sh <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh[i] <= '0;
      end
    end else begin
      en_sh <= ch_en;
      for (int i = 0; i < CHANNELS; i++) begin
        if (duty_we && (duty_sel == SEL_W'(i))) begin
          duty_sh[i] <= duty_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= en_act[i] & (cnt < duty_act[i]);
      end
    end
  end

endmodule
